// File: rtl/ffs_limb_serial_pkg.sv
// Shared constants and types for the limb-serial GF(p) subtractor.
package ff_pkg;
    localparam int WIDTH = 256;
    localparam int LIMB  = 64;
    localparam int NLIMB = WIDTH / LIMB;

    localparam logic [WIDTH-1:0] P_SECP256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {IDLE, SUB, FIX} ff_state_t;
    typedef logic [$clog2(NLIMB)-1:0] limb_idx_t;
    typedef logic [NLIMB-1:0][LIMB-1:0] limbs_t;
endpackage

// File: rtl/ffs_limb_serial_if.sv
// Handshake and operand/result bus for ffs_limb_serial.
// range_err exists only when FFS_RANGE_CHECK_EN is defined.
interface ffs_limb_serial_if;
    import ff_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
`ifdef FFS_RANGE_CHECK_EN
    logic             range_err;

    modport master (output start, a, b, input busy, done, diff, range_err);
    modport slave  (input start, a, b, output busy, done, diff, range_err);
`else
    modport master (output start, a, b, input busy, done, diff);
    modport slave  (input start, a, b, output busy, done, diff);
`endif
endinterface

// File: rtl/ffs_limb_serial_addsub.sv
// LIMB-bit combinational adder/subtractor; co is the borrow out when sub=1.
module ff_limb_addsub
    import ff_pkg::*;
(
    input  logic [LIMB-1:0] x,
    input  logic [LIMB-1:0] y,
    input  logic            ci,
    input  logic            sub,
    output logic [LIMB-1:0] r,
    output logic            co
);
    logic [LIMB:0] t;

    // x - y - ci lies in [-2^LIMB, 2^LIMB), so bit LIMB is set exactly on borrow.
    always_comb begin
        if (sub) t = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, ci};
        else     t = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, ci};
    end

    assign r  = t[LIMB-1:0];
    assign co = t[LIMB];
endmodule

// File: rtl/ffs_limb_serial.sv
// Limb-serial modular subtractor: diff = (a - b) mod P, constant latency 2*NLIMB.
// Optional operand range check enabled by defining FFS_RANGE_CHECK_EN.
module ffs_limb_serial
    import ff_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    ffs_limb_serial_if.slave bus
);
    ff_state_t        state, state_d;
    limb_idx_t        cnt;
    limbs_t           ar, br, res, res_nxt, p_l;
    logic             cy, neg, last, sub, co;
    logic [LIMB-1:0]  x, y, r;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] diff_q;

    assign p_l  = P_SECP256K1;
    assign last = (cnt == limb_idx_t'(NLIMB-1));
    assign sub  = (state == SUB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start) state_d = SUB;
            SUB:     if (last)      state_d = FIX;
            FIX:     if (last)      state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // One adder serves both phases; FIX always adds (P or 0) so timing is data-independent.
    assign x = sub ? ar[cnt] : res[cnt];
    assign y = sub ? br[cnt] : (neg ? p_l[cnt] : '0);

    ff_limb_addsub u_addsub (
        .x   (x),
        .y   (y),
        .ci  (cy),
        .sub (sub),
        .r   (r),
        .co  (co)
    );

    always_comb begin
        res_nxt      = res;
        res_nxt[cnt] = r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ar     <= '0;
            br     <= '0;
            res    <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
            neg    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            diff_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ar     <= bus.a;
                        br     <= bus.b;
                        cnt    <= '0;
                        cy     <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                SUB, FIX: begin
                    res <= res_nxt;
                    cnt <= last ? '0 : cnt + limb_idx_t'(1);
                    cy  <= last ? 1'b0 : co;
                    if (last && sub) neg <= co;
                    if (last && !sub) begin
                        diff_q <= res_nxt;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;

`ifdef FFS_RANGE_CHECK_EN
    // Serial a - P and b - P run alongside SUB; no final borrow means operand >= P.
    logic [1:0][LIMB-1:0] rx, rr;
    logic [1:0]           rbw, rco;
    logic                 rpend, rerr_q;

    assign rx[0] = ar[cnt];
    assign rx[1] = br[cnt];

    for (genvar j = 0; j < 2; j++) begin : g_rng
        ff_limb_addsub u_rng (
            .x   (rx[j]),
            .y   (p_l[cnt]),
            .ci  (rbw[j]),
            .sub (1'b1),
            .r   (rr[j]),
            .co  (rco[j])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbw    <= '0;
            rpend  <= 1'b0;
            rerr_q <= 1'b0;
        end else begin
            if (state == SUB) begin
                rbw <= last ? '0 : rco;
                if (last) rpend <= ~&rco;
            end
            if (state == IDLE && bus.start) rerr_q <= 1'b0;
            else if (state == FIX && last)  rerr_q <= rpend;
        end
    end

    assign bus.range_err = rerr_q;
`endif
endmodule
